// File: rtl/wb_regfile_sp_unit_if.sv
// rtl/wb_regfile_sp_unit_if.sv - bus interface for the writeback register file / SP unit
//
// Purpose : groups the writeback control word, write data, decode read ports
//           and architectural state outputs of wb_regfile_sp_unit.
// Modports: master - writeback control / decode side (drives control, reads state)
//           slave  - the register file unit itself
// Signals : write_en, sw1, sw2, sp_inc, sp_dec, ld_out, hlt_en, ra_wb, rb_wb,
//           wb_data, in_port, rd_addr_a, rd_addr_b            (master -> slave)
//           rd_data_a, rd_data_b, sp, out_port, out_valid,
//           halted, sp_fault                                    (slave -> master)

interface wb_regfile_sp_unit_if #(
    parameter int DATA_W = 8
);
    logic              write_en;
    logic              sw1;
    logic              sw2;
    logic              sp_inc;
    logic              sp_dec;
    logic              ld_out;
    logic              hlt_en;
    logic [1:0]        ra_wb;
    logic [1:0]        rb_wb;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] in_port;
    logic [1:0]        rd_addr_a;
    logic [1:0]        rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic [DATA_W-1:0] sp;
    logic [DATA_W-1:0] out_port;
    logic              out_valid;
    logic              halted;
    logic              sp_fault;

    modport master (
        output write_en, sw1, sw2, sp_inc, sp_dec, ld_out, hlt_en,
        output ra_wb, rb_wb, wb_data, in_port, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, sp, out_port, out_valid, halted, sp_fault
    );

    modport slave (
        input  write_en, sw1, sw2, sp_inc, sp_dec, ld_out, hlt_en,
        input  ra_wb, rb_wb, wb_data, in_port, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, sp, out_port, out_valid, halted, sp_fault
    );
endinterface

// File: rtl/wb_regfile_sp_unit.sv
// rtl/wb_regfile_sp_unit.sv - writeback register file R0..R3 with R3 as stack pointer
//
// Purpose : architectural state updated by the writeback stage: four registers
//           (R3 = SP), output-port register with one-cycle valid pulse, sticky
//           halt latch. Two combinational read ports with writeback bypass.
// Ports   : clk  - rising-edge clock
//           rst  - synchronous active-high reset
//           bus  - wb_regfile_sp_unit_if.slave (control word, data, read ports, state)
// Config  : SP_GUARD_EN - when defined, SP increment past all-ones or decrement
//           below zero is suppressed and sets the sticky sp_fault flag.
//           When undefined, SP wraps and sp_fault is tied low.

module wb_regfile_sp_unit #(
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] SP_RESET = 8'hFF
) (
    input  logic                        clk,
    input  logic                        rst,
    wb_regfile_sp_unit_if.slave         bus
);
    logic [DATA_W-1:0] rf_q [4];
    logic [DATA_W-1:0] rf_d [4];
    logic [DATA_W-1:0] out_port_q, out_port_d;
    logic              out_valid_q, out_valid_d;
    logic              halted_q, halted_d;
`ifdef SP_GUARD_EN
    logic              sp_fault_q, sp_fault_d;
`endif

    logic [1:0]        waddr;
    logic [DATA_W-1:0] wdata;
    logic              wr_live;
    logic              r3_written;

    assign waddr      = bus.sw1 ? bus.rb_wb : bus.ra_wb;
    assign wdata      = bus.sw2 ? bus.in_port : bus.wb_data;
    // Writes only exist while not halted; this also gates the read bypass.
    assign wr_live    = bus.write_en && !halted_q;
    assign r3_written = wr_live && (waddr == 2'd3);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rf_d[i] = rf_q[i];
        end
        out_port_d  = out_port_q;
        out_valid_d = 1'b0;
        halted_d    = halted_q | bus.hlt_en;
`ifdef SP_GUARD_EN
        sp_fault_d  = sp_fault_q;
`endif

        if (!halted_q) begin
            // A write targeting R3 (e.g. POP R3) overrides any SP step, and
            // inc+dec together cancel out.
            if (!r3_written && (bus.sp_inc != bus.sp_dec)) begin
                if (bus.sp_inc) begin
`ifdef SP_GUARD_EN
                    if (rf_q[3] == '1) begin
                        sp_fault_d = 1'b1;
                    end else begin
                        rf_d[3] = rf_q[3] + DATA_W'(1);
                    end
`else
                    rf_d[3] = rf_q[3] + DATA_W'(1);
`endif
                end else begin
`ifdef SP_GUARD_EN
                    if (rf_q[3] == '0) begin
                        sp_fault_d = 1'b1;
                    end else begin
                        rf_d[3] = rf_q[3] - DATA_W'(1);
                    end
`else
                    rf_d[3] = rf_q[3] - DATA_W'(1);
`endif
                end
            end

            if (wr_live) begin
                rf_d[waddr] = wdata;
            end

            // The port takes the pre-edge register value, not the bypassed one.
            if (bus.ld_out) begin
                out_port_d  = rf_q[bus.rb_wb];
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_q[0]     <= '0;
            rf_q[1]     <= '0;
            rf_q[2]     <= '0;
            rf_q[3]     <= SP_RESET;
            out_port_q  <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
`ifdef SP_GUARD_EN
            sp_fault_q  <= 1'b0;
`endif
        end else begin
            for (int i = 0; i < 4; i++) begin
                rf_q[i] <= rf_d[i];
            end
            out_port_q  <= out_port_d;
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
`ifdef SP_GUARD_EN
            sp_fault_q  <= sp_fault_d;
`endif
        end
    end

    assign bus.rd_data_a = (wr_live && (waddr == bus.rd_addr_a)) ? wdata : rf_q[bus.rd_addr_a];
    assign bus.rd_data_b = (wr_live && (waddr == bus.rd_addr_b)) ? wdata : rf_q[bus.rd_addr_b];
    assign bus.sp        = rf_q[3];
    assign bus.out_port  = out_port_q;
    assign bus.out_valid = out_valid_q;
    assign bus.halted    = halted_q;
`ifdef SP_GUARD_EN
    assign bus.sp_fault  = sp_fault_q;
`else
    assign bus.sp_fault  = 1'b0;
`endif
endmodule
